audio_clk_ctrl: RTL

//  Stage directly downstream of the fir8bit PLL. Runs on the PLL output (11.2896 MHz = 256*44.1 kHz).

---
 rtl/audio_clk_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/audio_clk_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/audio_clk_pkg.sv
// Shared types and default constants for the audio clock/reset controller.
package audio_clk_pkg;

  // Qualification FSM states; encoding is also exported on the debug port.
  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD_RST  = 2'd2,
    RUN       = 2'd3
  } state_e;

  // Defaults for an 11.2896 MHz clock (256 * 44.1 kHz).
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_RESET_HOLD_CYCLES  = 16;
  localparam int unsigned DEF_FS_DIV             = 256;
  localparam int unsigned DEF_BCLK_DIV           = 4;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, async active-high reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_clk_ctrl.sv
// PLL lock qualification, datapath reset sequencing and I2S/sample-rate
// frame generation. Runs entirely on the PLL output clock.
//
// Handshake note: this block has no valid/ready streams. "ready" is a level
// that is high exactly while the FSM is in RUN; sample_tick is a one-cycle
// strobe that is only ever produced while ready is high.
module audio_clk_ctrl
  import audio_clk_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
  parameter int unsigned FS_DIV             = DEF_FS_DIV,
  parameter int unsigned BCLK_DIV           = DEF_BCLK_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       clear_lock_lost,
  output logic       dsp_rst,
  output logic       ready,
  output logic       sample_tick,
  output logic       bclk,
  output logic       lrclk,
  output logic       lock_lost,
  output logic [1:0] dbg_state_o
);

  localparam int unsigned CNT_W     = $clog2(LOCK_STABLE_CYCLES);
  localparam int unsigned DIV_W     = $clog2(FS_DIV);
  localparam int unsigned BCLK_BIT  = $clog2(BCLK_DIV) - 1;
  localparam int unsigned LRCLK_BIT = DIV_W - 1;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(FS_DIV - 1);

  logic             lk_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             lock_lost_q, lock_lost_d;
  logic             set_lost;
  logic             run_d;
  logic             dsp_rst_q, ready_q, tick_q, bclk_q, lrclk_q;

  // Lock is asynchronous to clk; only the synchronized copy is used below.
  sync_2ff u_lock_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  // Next-state logic: qualify lock, hold reset, then run; any low lk_s restarts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    set_lost    = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk_s) state_d = STABLE;
      end
      STABLE: begin
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = HOLD_RST;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD_RST: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          cnt_d    = '0;
          set_lost = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          set_lost = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    // A loss event wins over a simultaneous clear request.
    if (set_lost)             lock_lost_d = 1'b1;
    else if (clear_lock_lost) lock_lost_d = 1'b0;
    else                      lock_lost_d = lock_lost_q;
  end

  // Frame divider: starts at 0 on the first RUN cycle, parked at 0 otherwise.
  always_comb begin
    run_d = (state_d == RUN);
    div_d = '0;
    if (run_d && (state_q == RUN)) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // State, counters and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      div_q       <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  // Registered outputs derived from next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      tick_q    <= 1'b0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      dsp_rst_q <= !run_d;
      ready_q   <= run_d;
      tick_q    <= run_d && (div_d == DIV_LAST);
      bclk_q    <= run_d && div_d[BCLK_BIT];
      lrclk_q   <= run_d && div_d[LRCLK_BIT];
    end
  end

  assign dsp_rst     = dsp_rst_q;
  assign ready       = ready_q;
  assign sample_tick = tick_q;
  assign bclk        = bclk_q;
  assign lrclk       = lrclk_q;
  assign lock_lost   = lock_lost_q;
  assign dbg_state_o = state_q;

endmodule
